// File: rtl/npu_stream_loader.sv
// Header-driven stream loader: decodes a layer/neuron header from the host stream,
// then forwards the derived number of weight words and input words to the PE array.
module npu_stream_loader #(
   parameter int DW         = 32,
   parameter int MAX_LAYERS = 4,
   parameter int NW         = 6,
   parameter int CW         = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic [DW-1:0]            s_data,
   output logic                     s_ready,
   input  logic                     abort,
   output logic [3:0]               cfg_num_layers,
   output logic [MAX_LAYERS*NW-1:0] cfg_neurons,
   output logic                     cfg_act,
   output logic                     cfg_valid,
   output logic                     w_valid,
   output logic [DW-1:0]            w_data,
   input  logic                     w_ready,
   output logic                     x_valid,
   output logic [DW-1:0]            x_data,
   input  logic                     x_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   typedef enum logic [2:0] {IDLE, HDR_N, HDR_A, WGT, INP, DONE, ERR} state_t;

   localparam logic [3:0] MAXL = 4'(MAX_LAYERS);

   state_t                   state_q, state_d;
   logic [3:0]               layers_q, layers_d;
   logic [MAX_LAYERS*NW-1:0] neur_q, neur_d;
   logic                     act_q, act_d;
   logic                     cfgv_q, cfgv_d;
   logic [CW-1:0]            wc_q, wc_d;
   logic [CW-1:0]            xc_q, xc_d;
   logic [3:0]               k_q, k_d;
   logic [NW:0]              prev_q, prev_d;

   logic                     xfer;
   logic                     abort_go;
   logic [3:0]               hdr_l;
   logic [NW:0]              n_cur;
   logic [2*NW+1:0]          prod;

   assign hdr_l    = {1'b0, s_data[2:0]} + 4'd2;
   assign n_cur    = {1'b0, s_data[NW-1:0]} + (NW+1)'(1);
   assign prod     = (2*NW+2)'(prev_q) * (2*NW+2)'(n_cur);
   assign abort_go = abort && (state_q != ERR);
   assign xfer     = s_valid && s_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort_go) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (xfer) state_d = (hdr_l > MAXL) ? ERR : HDR_N;
            HDR_N:   if (xfer && ((k_q + 4'd1) == layers_q)) state_d = HDR_A;
            HDR_A:   if (xfer) state_d = WGT;
            WGT:     if (xfer && (wc_q == CW'(1))) state_d = INP;
            INP:     if (xfer && (xc_q == CW'(1))) state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      s_ready = 1'b0;
      w_valid = 1'b0;
      w_data  = '0;
      x_valid = 1'b0;
      x_data  = '0;
      case (state_q)
         IDLE, HDR_N, HDR_A: s_ready = 1'b1;
         WGT: begin
            s_ready = w_ready;
            w_valid = s_valid;
            w_data  = s_data;
         end
         INP: begin
            s_ready = x_ready;
            x_valid = s_valid;
            x_data  = s_data;
         end
         default: ;
      endcase
      // Reset must hold s_ready low even though IDLE normally advertises readiness.
      if (rst) s_ready = 1'b0;
   end

   assign busy           = (state_q != IDLE);
   assign err            = (state_q == ERR);
   assign done           = (state_q == DONE) && !abort;
   assign cfg_num_layers = layers_q;
   assign cfg_neurons    = neur_q;
   assign cfg_act        = act_q;
   assign cfg_valid      = cfgv_q;

   always_comb begin
      layers_d = layers_q;
      neur_d   = neur_q;
      act_d    = act_q;
      cfgv_d   = 1'b0;
      wc_d     = wc_q;
      xc_d     = xc_q;
      k_d      = k_q;
      prev_d   = prev_q;
      if (abort_go) begin
         layers_d = '0;
         neur_d   = '0;
         act_d    = 1'b0;
         wc_d     = '0;
         xc_d     = '0;
         k_d      = '0;
         prev_d   = '0;
      end else if (xfer) begin
         case (state_q)
            IDLE: begin
               if (hdr_l <= MAXL) begin
                  layers_d = hdr_l;
                  neur_d   = '0;
                  wc_d     = '0;
                  k_d      = '0;
               end
            end
            HDR_N: begin
               for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
                  if (k_q == 4'(i)) neur_d[i*NW +: NW] = s_data[NW-1:0];
               end
               // Weights n_(k-1)*n_k plus n_k biases accumulate as each count arrives.
               if (k_q != 4'd0) wc_d = wc_q + CW'(prod) + CW'(n_cur);
               prev_d = n_cur;
               k_d    = k_q + 4'd1;
            end
            HDR_A: begin
               act_d  = s_data[0];
               cfgv_d = 1'b1;
            end
            WGT: begin
               wc_d = wc_q - CW'(1);
               if (wc_q == CW'(1)) xc_d = CW'(neur_q[NW-1:0]) + CW'(1);
            end
            INP: xc_d = xc_q - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layers_q <= '0;
         neur_q   <= '0;
         act_q    <= 1'b0;
         cfgv_q   <= 1'b0;
         wc_q     <= '0;
         xc_q     <= '0;
         k_q      <= '0;
         prev_q   <= '0;
      end else begin
         layers_q <= layers_d;
         neur_q   <= neur_d;
         act_q    <= act_d;
         cfgv_q   <= cfgv_d;
         wc_q     <= wc_d;
         xc_q     <= xc_d;
         k_q      <= k_d;
         prev_q   <= prev_d;
      end
   end

endmodule

// File: doc/npu_stream_loader.md
NPU_STREAM_LOADER -- requirements
Module: npu_stream_loader

Interface
REQ-001 Parameter DW, default 32, width of host and downstream data words.
REQ-002 Parameter MAX_LAYERS, default 4, maximum layer count supported; legal range 2..8.
REQ-003 Parameter NW, default 6, neuron-count field width; a layer holds at most 2^NW neurons.
REQ-004 Parameter CW, default 16, width of the transfer counters; must satisfy (MAX_LAYERS-1)*(2^(2*NW)+2^NW) < 2^CW.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 s_valid  in  1  host word valid.
REQ-008 s_data  in  DW  host word.
REQ-009 s_ready  out  1  loader accepts s_data this cycle.
REQ-010 abort  in  1  synchronous abort of the current load.
REQ-011 cfg_num_layers  out  4  decoded layer count L.
REQ-012 cfg_neurons  out  MAX_LAYERS*NW  slot i holds (count_i - 1); slots >= L are 0.
REQ-013 cfg_act  out  1  activation enable.
REQ-014 cfg_valid  out  1  one-cycle pulse when the header is complete.
REQ-015 w_valid, w_data, w_ready  out/out/in  1/DW/1  weight-and-bias stream to the PE array.
REQ-016 x_valid, x_data, x_ready  out/out/in  1/DW/1  input-vector stream to the PE array.
REQ-017 busy  out  1  high whenever state != IDLE.
REQ-018 done  out  1  one-cycle pulse after the last input word transfers.
REQ-019 err  out  1  sticky header error.

Function
REQ-020 The loader SHALL implement the states IDLE, HDR_N, HDR_A, WGT, INP, DONE and ERR.
REQ-021 IDLE: s_ready=1; on a transfer, L = s_data[2:0]+2. If L > MAX_LAYERS, go to ERR; otherwise latch cfg_num_layers and go to HDR_N.
REQ-022 HDR_N: s_ready=1; accept exactly L words; word k gives n_k = s_data[NW-1:0]+1, which is stored in slot k.
REQ-023 On each count word with k>=1, the weight counter wc SHALL accumulate n_(k-1)*n_k + n_k (weights plus biases); the product is computed within the accepting cycle.
REQ-024 After the L-th count word, go to HDR_A.
REQ-025 HDR_A: s_ready=1; on a transfer, cfg_act = s_data[0]. Pulse cfg_valid on the same edge that enters WGT.
REQ-026 WGT: w_valid=s_valid, w_data=s_data, s_ready=w_ready (combinational pass-through). Decrement wc on each transfer; after the transfer at wc=1, go to INP with the input counter loaded to n_0.
REQ-027 INP: same pass-through on the x port. After the n_0-th transfer, go to DONE.
REQ-028 DONE: done=1 for exactly one cycle, s_ready=0, then IDLE. cfg_* hold their values until the next header overwrites them.
REQ-029 In any state, the idle stream port SHALL drive valid=0. w_valid and x_valid are never high together.
REQ-030 No word may be lost or duplicated under any valid/ready pattern; s_valid may deassert mid-stream without effect.
REQ-031 ERR: s_ready=0, err=1; the only exit is rst (abort is ignored).
REQ-032 abort=1 in IDLE..INP or DONE SHALL move to IDLE on the next edge and clear the counters, the neuron slots and cfg_*. No done, no cfg_valid. Abort takes priority over a simultaneous transfer, and that transfer is not counted.
REQ-033 Header words arriving back-to-back SHALL be accepted at one per cycle.
REQ-034 Latency from the first header word to cfg_valid SHALL be L+2 accepted words, with zero added cycles.

Reset
REQ-035 While rst=1: state IDLE; wc, the input counter, cfg_num_layers, cfg_neurons, cfg_act, cfg_valid, w_valid, x_valid, done, err and busy are all 0; w_data and x_data are 0; s_ready=0.
REQ-036 s_ready rises in the first cycle after rst deasserts.
REQ-037 A reset asserted mid-load discards the load with no partial done.

Verification
REQ-038 Scenario: rst pulse during WGT -> all outputs 0 immediately (asynchronously); after release busy=0 and s_ready=1.
REQ-039 Scenario: header 0,9,0,0 then 11 weight words then 10 input words -> cfg_valid once with L=2, n=(10,1), cfg_act=0; exactly 11 w transfers, 10 x transfers, done one cycle after the last x.
REQ-040 Scenario: header 1,1,2,0,1 -> L=3, n=(2,3,1), cfg_act=1; wc=13 (2*3+3 + 3*1+1), then 2 input words.
REQ-041 Scenario: toggle w_ready every 3 cycles with s_valid held high -> s_ready mirrors w_ready; the w_data sequence equals the host sequence exactly.
REQ-042 Scenario: header word 3 with MAX_LAYERS=4 -> err=1 and s_ready=0 permanently; abort has no effect; cleared only by rst.
REQ-043 Scenario: abort on the 5th weight transfer -> that word not counted; IDLE next cycle; no done; a following full load completes correctly.
